// File: rtl/dev_bridge.sv
// CPU-side initiator of the memory-mapped device bus: decodes single-word
// load/store requests to two timer devices and registers interrupt lines into HWINT.
module dev_bridge #(
  parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_rdata,
  input  logic [31:0] dev1_rdata,
  input  logic        dev0_irq,
  input  logic        dev1_irq,
  input  logic        ext_irq,
  output logic [5:0]  hwint,
  output logic [1:0]  dbg_state
);

  // Handshake: cpu_req is sampled only in IDLE; cpu_ready is a one-cycle pulse
  // (in RESP) and cpu_err/cpu_rdata are meaningful only while cpu_ready is high.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic        r_sel;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [5:0]  r_hwint;

  logic [31:0] w_off0;
  logic [31:0] w_off1;
  logic        w_in0;
  logic        w_in1;
  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_legal;

  // Window hit is computed on the offset from each base so unaligned bases still decode.
  assign w_off0  = cpu_addr - TIMER0_BASE;
  assign w_off1  = cpu_addr - TIMER1_BASE;
  assign w_in0   = (w_off0 < 32'd12);
  assign w_in1   = (w_off1 < 32'd12);
  assign w_sel   = !w_in0;
  assign w_off   = w_sel ? w_off1[3:2] : w_off0[3:2];
  assign w_legal = (cpu_be == 4'hF) && (cpu_addr[1:0] == 2'b00) && (w_in0 || w_in1) &&
                   !(cpu_we && (w_off == 2'd2));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req) begin
          w_next = w_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Error transactions skip ISSUE, so they can never raise a write strobe.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = 32'd0;
    dev0_we   = 1'b0;
    dev1_we   = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        dev0_we = r_we && !r_sel;
        dev1_we = r_we && r_sel;
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        cpu_err   = r_err;
        cpu_rdata = r_rdata;
      end
      default: begin
        cpu_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_sel   <= 1'b0;
      r_off   <= 2'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && cpu_req) begin
        r_we    <= cpu_we;
        r_sel   <= w_sel;
        r_off   <= w_off;
        r_wdata <= cpu_wdata;
        r_err   <= !w_legal;
        r_rdata <= 32'd0;
      end else if (r_state == ST_ISSUE && !r_we) begin
        r_rdata <= r_sel ? dev1_rdata : dev0_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hwint <= 6'd0;
    end else begin
      r_hwint <= {3'b000, ext_irq, dev1_irq, dev0_irq};
    end
  end

  assign dev_addr  = r_off;
  assign dev_wdata = r_wdata;
  assign hwint     = r_hwint;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dev_bridge.sv
// Bench for dev_bridge: table vectors, randomized transactions against a
// reference model, back-to-back, interrupt and mid-transaction reset sequences.
module tb_dev_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic        dev0_we;
  logic        dev1_we;
  logic [31:0] dev0_rdata;
  logic [31:0] dev1_rdata;
  logic        dev0_irq;
  logic        dev1_irq;
  logic        ext_irq;
  logic [5:0]  hwint;
  logic [1:0]  dbg_state;

  logic [31:0] d0 [4];
  logic [31:0] d1 [4];
  logic [5:0]  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign dev0_rdata = d0[dev_addr];
  assign dev1_rdata = d1[dev_addr];

  dev_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_be     (cpu_be),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev0_we    (dev0_we),
    .dev1_we    (dev1_we),
    .dev0_rdata (dev0_rdata),
    .dev1_rdata (dev1_rdata),
    .dev0_irq   (dev0_irq),
    .dev1_irq   (dev1_irq),
    .ext_irq    (ext_irq),
    .hwint      (hwint),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: legality and load data straight from the address-map rules.
  function automatic logic model_err(input logic we, input logic [31:0] addr, input logic [3:0] be);
    int unsigned a;
    int unsigned off;
    logic        in0;
    logic        in1;
    a   = addr;
    in0 = (a >= 32'h7F00) && (a <= 32'h7F0B);
    in1 = (a >= 32'h7F10) && (a <= 32'h7F1B);
    off = in0 ? a - 32'h7F00 : a - 32'h7F10;
    return !((be == 4'hF) && (a % 4 == 0) && (in0 || in1) && !(we && off == 8));
  endfunction

  function automatic logic [31:0] model_rdata(input logic we, input logic [31:0] addr, input logic [3:0] be);
    int unsigned a;
    a = addr;
    if (model_err(we, addr, be) || we) return 32'd0;
    if (a < 32'h7F10) return d0[(a - 32'h7F00) / 4];
    return d1[(a - 32'h7F10) / 4];
  endfunction

  // driver + monitor for one transaction
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rdata);
    int          ready_cyc;
    int          strobes;
    int          strobe_cyc;
    logic        strobe_dev;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic        g_err;
    logic [31:0] g_rdata;
    logic        exp_strobe;
    ready_cyc  = 0;
    strobes    = 0;
    strobe_cyc = 0;
    strobe_dev = 1'b0;
    s_addr     = 2'd0;
    s_wdata    = 32'd0;
    g_err      = 1'b0;
    g_rdata    = 32'd0;
    exp_strobe = !exp_err && we;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_be    = be;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req   = 1'b0;
    cpu_we    = 1'($urandom);
    cpu_addr  = $urandom;
    cpu_be    = 4'($urandom);
    cpu_wdata = $urandom;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (dev0_we || dev1_we) begin
        strobes    = strobes + int'(dev0_we) + int'(dev1_we);
        strobe_cyc = cyc;
        strobe_dev = dev1_we;
        s_addr     = dev_addr;
        s_wdata    = dev_wdata;
      end
      if (cpu_ready) begin
        ready_cyc = cyc;
        g_err     = cpu_err;
        g_rdata   = cpu_rdata;
        break;
      end
      @(negedge clk);
    end
    check({name, ":latency"}, ready_cyc, exp_err ? 1 : 2);
    check({name, ":err"}, 32'(g_err), 32'(exp_err));
    check({name, ":rdata"}, g_rdata, exp_rdata);
    check({name, ":strobes"}, strobes, exp_strobe ? 1 : 0);
    if (exp_strobe && strobes == 1) begin
      check({name, ":strobe_cyc"}, strobe_cyc, 1);
      check({name, ":strobe_dev"}, 32'(strobe_dev), 32'(addr >= 32'h7F10));
      check({name, ":dev_addr"}, 32'(s_addr), 32'(addr[3:2]));
      check({name, ":dev_wdata"}, s_wdata, wd);
    end
  endtask

  vec_t vecs [11];

  initial begin
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wd;
    logic [5:0]  irq_v;
    logic [5:0]  exp_h;
    int          ready_cnt;

    d0[0] = 32'hD000_0000; d0[1] = 32'hD000_1111; d0[2] = 32'hD000_2222; d0[3] = 32'hDEAD_0003;
    d1[0] = 32'h1000_0000; d1[1] = 32'h0000_1234; d1[2] = 32'h1000_2222; d1[3] = 32'hBEEF_0003;

    vecs[0]  = '{"st_d0_ctrl",    1'b1, 32'h7F00, 4'hF, 32'h9,         1'b0, 32'h0};
    vecs[1]  = '{"ld_d1_preset",  1'b0, 32'h7F14, 4'hF, 32'h0,         1'b0, 32'h0000_1234};
    vecs[2]  = '{"st_d0_count",   1'b1, 32'h7F08, 4'hF, 32'h55,        1'b1, 32'h0};
    vecs[3]  = '{"ld_d0_off_c",   1'b0, 32'h7F0C, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{"ld_unmapped",   1'b0, 32'h7F20, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{"st_partial_be", 1'b1, 32'h7F04, 4'h3, 32'h77,        1'b1, 32'h0};
    vecs[6]  = '{"ld_misalign",   1'b0, 32'h7F02, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{"ld_d0_count",   1'b0, 32'h7F08, 4'hF, 32'h0,         1'b0, 32'hD000_2222};
    vecs[8]  = '{"st_d1_count",   1'b1, 32'h7F18, 4'hF, 32'h1,         1'b1, 32'h0};
    vecs[9]  = '{"st_d1_preset",  1'b1, 32'h7F14, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[10] = '{"ld_below_win",  1'b0, 32'h7EFC, 4'hF, 32'h0,         1'b1, 32'h0};

    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_be    = 4'd0;
    cpu_wdata = 32'd0;
    dev0_irq  = 1'b1;
    dev1_irq  = 1'b1;
    ext_irq   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst:state", 32'(dbg_state), 32'd0);
    check("rst:ready", 32'(cpu_ready), 32'd0);
    check("rst:err", 32'(cpu_err), 32'd0);
    check("rst:rdata", cpu_rdata, 32'd0);
    check("rst:dev_addr", 32'(dev_addr), 32'd0);
    check("rst:dev_wdata", dev_wdata, 32'd0);
    check("rst:we", 32'({dev1_we, dev0_we}), 32'd0);
    check("rst:hwint", 32'(hwint), 32'd0);
    dev0_irq = 1'b0;
    dev1_irq = 1'b0;
    ext_irq  = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
              vecs[i].exp_err, vecs[i].exp_rdata);
    end

    for (int i = 0; i < 150; i++) begin
      r_we   = 1'($urandom);
      r_addr = 32'h7EF0 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_be   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      r_wd   = $urandom;
      run_txn($sformatf("rnd%0d", i), r_we, r_addr, r_be, r_wd,
              model_err(r_we, r_addr, r_be), model_rdata(r_we, r_addr, r_be));
    end

    // back-to-back: request held high, ready every third cycle
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h7F18;
    cpu_be   = 4'hF;
    ready_cnt = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      check($sformatf("b2b:ready_c%0d", cyc), 32'(cpu_ready), 32'((cyc % 3) == 2));
      if (cpu_ready) begin
        ready_cnt++;
        check($sformatf("b2b:rdata_c%0d", cyc), cpu_rdata, d1[2]);
      end
    end
    cpu_req = 1'b0;
    check("b2b:count", ready_cnt, 4);
    @(negedge clk);
    check("b2b:idle", 32'(dbg_state), 32'd0);

    // interrupts: directed then random, one-cycle registered delay
    dev1_irq = 1'b1;
    check("irq:not_yet", 32'(hwint), 32'd0);
    @(negedge clk);
    check("irq:dev1", 32'(hwint), 32'b000010);
    ext_irq = 1'b1;
    @(negedge clk);
    check("irq:dev1_ext", 32'(hwint), 32'b000110);
    dev1_irq = 1'b0;
    ext_irq  = 1'b0;
    @(negedge clk);
    check("irq:clear", 32'(hwint), 32'd0);
    for (int i = 0; i < 20; i++) begin
      irq_v    = 6'($urandom_range(0, 7));
      dev0_irq = irq_v[0];
      dev1_irq = irq_v[1];
      ext_irq  = irq_v[2];
      exp_q.push_back(irq_v);
      @(negedge clk);
      exp_h = exp_q.pop_front();
      check($sformatf("irq:rnd%0d", i), 32'(hwint), 32'(exp_h));
    end
    dev0_irq = 1'b0;
    dev1_irq = 1'b0;
    ext_irq  = 1'b0;
    @(negedge clk);

    // reset during ISSUE of a store to device 1
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h7F10;
    cpu_be    = 4'hF;
    cpu_wdata = 32'hA5A5_0001;
    @(negedge clk);
    cpu_req = 1'b0;
    check("mid_rst:in_issue", 32'(dbg_state), 32'd1);
    check("mid_rst:strobe", 32'(dev1_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst:state", 32'(dbg_state), 32'd0);
    check("mid_rst:ready", 32'(cpu_ready), 32'd0);
    check("mid_rst:we", 32'({dev1_we, dev0_we}), 32'd0);
    check("mid_rst:dev_addr", 32'(dev_addr), 32'd0);
    check("mid_rst:dev_wdata", dev_wdata, 32'd0);
    check("mid_rst:rdata", cpu_rdata, 32'd0);
    check("mid_rst:hwint", 32'(hwint), 32'd0);
    @(negedge clk);
    check("mid_rst:no_ready", 32'(cpu_ready), 32'd0);
    run_txn("post_rst_load", 1'b0, 32'h7F04, 4'hF, 32'd0, 1'b0, 32'hD000_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dev_bridge.md
# dev_bridge

CPU-side initiator of the memory-mapped device bus. It accepts single-word load/store requests from the pipeline and decodes them to two Timer-class devices. It drives each device's `ADDR_I[3:2]`/`WE_I`/`DAT_I` port and returns the read data with a ready/error handshake. It also registers device interrupt lines into the CP0 `HWINT` vector.

## Interface
Parameters:
- `TIMER0_BASE`, default 32'h0000_7F00: base of device 0 window, which is 12 bytes (offsets 0x0/0x4/0x8).
- `TIMER1_BASE`, default 32'h0000_7F10: base of device 1 window, which is 12 bytes.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  request strobe, sampled only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address.
- `cpu_be`  in  4  byte enables.
- `cpu_wdata`  in  32  store data.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  valid with `cpu_ready`; 1 = bus error.
- `cpu_rdata`  out  32  load data, valid with `cpu_ready`.
- `dev_addr`  out  2  word offset `[3:2]` to both devices.
- `dev_wdata`  out  32  write data to both devices.
- `dev0_we`  out  1  write strobe, device 0.
- `dev1_we`  out  1  write strobe, device 1.
- `dev0_rdata`  in  32  combinational read data from device 0, a function of `dev_addr`.
- `dev1_rdata`  in  32  combinational read data from device 1.
- `dev0_irq`, `dev1_irq`, `ext_irq`  in  1 each  level interrupt requests.
- `hwint`  out  6  registered interrupt vector to CP0.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If `cpu_req`=1, latch `cpu_we`, `cpu_wdata`, the decoded device select and offset `cpu_addr[3:2]`.
  - If the request decodes legal, go to ISSUE; otherwise go to RESP with the error flag set.
  - If `cpu_req`=0, stay in IDLE.
- **Decode.** A request is legal only if all of the following hold:
  - `cpu_be` = 4'hF;
  - `cpu_addr[1:0]` = 0;
  - `cpu_addr` lies in `[BASE, BASE+0xB]` of either device;
  - it is not a store to offset 0x8 (COUNT is read-only).
- **Illegal requests**
  - Offset 0xC inside a window is illegal.
  - Any other address is illegal.
- **ISSUE (exactly one cycle)**
  - `dev_addr`/`dev_wdata` present the latched values.
  - For a store, the selected `devN_we`=1 for this cycle only; the device captures it on the closing edge.
  - For a load, no strobe is asserted, and the selected `devN_rdata` is captured into the rdata register at the closing edge.
  - Next state: RESP.
- **RESP (exactly one cycle)**
  - `cpu_ready`=1.
  - `cpu_err` = the latched error flag.
  - `cpu_rdata` = the captured value for a legal load; 0 for stores and errors.
  - Next state: IDLE.
- `cpu_req` is ignored in ISSUE and RESP. A request held high re-issues in the cycle after RESP; the pipeline must drop it on `cpu_ready`.
- An error transaction never asserts any `devN_we`.
- `dev_addr`/`dev_wdata` hold the last latched values outside ISSUE.
- **Interrupts:** `hwint` = {3'b000, `ext_irq`, `dev1_irq`, `dev0_irq`}, registered every cycle independent of the FSM.

## Timing
- **Reset values:** state IDLE; `cpu_ready`=0, `cpu_err`=0, `cpu_rdata`=0, `dev_addr`=0, `dev_wdata`=0, `dev0_we`=0, `dev1_we`=0, `hwint`=0.
- **Reset during ISSUE or RESP:** the transaction is abandoned.
  - No strobe is asserted in the following cycle.
  - No `cpu_ready` is issued.
- **Latency**, with `cpu_req` sampled at edge E0:
  - legal transaction: ISSUE in cycle E0→E1, `cpu_ready` in cycle E1→E2;
  - error transaction: `cpu_ready`+`cpu_err` in cycle E0→E1.
- **Throughput:** at most one transaction per 3 cycles for legal requests, one per 2 cycles for error requests.
- **Interrupt latency:** a `devN_irq` edge appears on `hwint` one cycle later; deassertion also takes one cycle.
- The device load path is combinational within ISSUE; no device may add a wait state.

## Test plan
- **Store to device 0 CTRL:** store 32'h9 to 0x7F00 → `dev0_we`=1 for exactly one cycle, `dev_addr`=0, `dev_wdata`=32'h9; `cpu_ready`=1 with `cpu_err`=0 two cycles after the request.
- **Load from device 1 PRESET:** `dev1_rdata`=32'h1234 when `dev_addr`=1; load 0x7F14 → `cpu_rdata`=32'h1234, `cpu_err`=0, no `devN_we` asserted.
- **Error cases:** each of the following gives `cpu_ready`+`cpu_err`=1 one cycle after the request, no strobe, `cpu_rdata`=0:
  - store 0x7F08;
  - load 0x7F0C;
  - load 0x7F20;
  - store with `cpu_be`=4'h3 to 0x7F04.
- **Back-to-back requests:** `cpu_req` held high with a load to 0x7F18 → `cpu_ready` pulses every 3rd cycle and `cpu_req` is never sampled in ISSUE/RESP.
- **Interrupts:** raise `dev1_irq` → `hwint`=6'b000010 one cycle later; raise `ext_irq` as well → 6'b000110; drop both → 0 one cycle later.
- **Reset mid-transaction:** assert `reset` during the ISSUE of a store to 0x7F10 → no `cpu_ready`, all outputs 0, FSM in IDLE; a new load afterwards completes normally.
